// File: rtl/i2c_bit_engine.sv
// I2C master bit engine: sequences START / WRITE / READ / STOP on SDA against the
// sensed SCL of an external SCL generator, and detects arbitration loss while writing.
module i2c_bit_engine #(
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_data,
  input  logic       tx_ack,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       rx_ack,
  output logic       busy,
  output logic       arb_lost,
  output logic       scl_en,
  output logic       scl_wait,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o
);

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_START, S_WRITE, S_READ, S_ACK, S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic             scl_q;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       bit_q, bit_d;
  logic             phase_q, phase_d;
  logic             rstart_q, rstart_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_ack_q, tx_ack_d;
  logic             sda_q, sda_d;
  logic             scl_en_q, scl_en_d;
  logic             scl_wait_q, scl_wait_d;
  logic             done_q, done_d;
  logic             arb_q, arb_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_ack_q, rx_ack_d;

  logic scl_rise, scl_fall, accept, hold_done, arb_hit, hold_restart;

  assign scl_rise  = scl_i & ~scl_q;
  assign scl_fall  = ~scl_i & scl_q;
  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign accept    = cmd_valid & cmd_ready;
  assign hold_done = (hold_q == CNT_W'(HOLD_CYC));
  // Only reachable in WRITE, where cmd_ready is low, so loss always wins over a new command.
  assign arb_hit   = (state_q == S_WRITE) & scl_rise & sda_q & ~sda_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scl_q      <= 1'b1;
      hold_q     <= '0;
      bit_q      <= 4'd0;
      phase_q    <= 1'b0;
      rstart_q   <= 1'b0;
      shift_q    <= 8'h00;
      tx_ack_q   <= 1'b0;
      sda_q      <= 1'b1;
      scl_en_q   <= 1'b0;
      scl_wait_q <= 1'b0;
      done_q     <= 1'b0;
      arb_q      <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_ack_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      scl_q      <= scl_i;
      hold_q     <= hold_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      rstart_q   <= rstart_d;
      shift_q    <= shift_d;
      tx_ack_q   <= tx_ack_d;
      sda_q      <= sda_d;
      scl_en_q   <= scl_en_d;
      scl_wait_q <= scl_wait_d;
      done_q     <= done_d;
      arb_q      <= arb_d;
      rx_data_q  <= rx_data_d;
      rx_ack_q   <= rx_ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && cmd == CMD_START) state_d = S_START;
      S_HOLD: begin
        if (accept) begin
          case (cmd)
            CMD_START: state_d = S_START;
            CMD_WRITE: state_d = S_WRITE;
            CMD_READ:  state_d = S_READ;
            default:   state_d = S_STOP;
          endcase
        end
      end
      S_START: if (phase_q && scl_fall) state_d = S_HOLD;
      S_WRITE: begin
        if (arb_hit)                         state_d = S_IDLE;
        else if (scl_fall && bit_q == 4'd7)  state_d = S_ACK;
      end
      S_ACK:   if (scl_fall) state_d = S_HOLD;
      S_READ:  if (scl_fall && bit_q == 4'd8) state_d = S_HOLD;
      S_STOP:  if (phase_q && hold_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_d      = bit_q;
    phase_d    = phase_q;
    rstart_d   = rstart_q;
    shift_d    = shift_q;
    tx_ack_d   = tx_ack_q;
    sda_d      = sda_q;
    scl_en_d   = scl_en_q;
    scl_wait_d = scl_wait_q;
    done_d     = 1'b0;
    arb_d      = 1'b0;
    rx_data_d  = rx_data_q;
    rx_ack_d   = rx_ack_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_START: begin sda_d = 1'b0; rstart_d = 1'b0; phase_d = 1'b0; bit_d = 4'd0; end
            CMD_STOP:  done_d = 1'b1;
            default:   begin done_d = 1'b1; rx_ack_d = 1'b1; end
          endcase
        end
      end
      S_HOLD: begin
        scl_wait_d = 1'b1;
        if (accept) begin
          shift_d  = tx_data;
          tx_ack_d = tx_ack;
          bit_d    = 4'd0;
          phase_d  = 1'b0;
          if (cmd == CMD_START) begin
            // Repeated start: release SDA while SCL is low so it can fall while SCL is high.
            sda_d      = 1'b1;
            scl_wait_d = 1'b0;
            rstart_d   = 1'b1;
          end
        end
      end
      S_START: begin
        if (!phase_q) begin
          if (rstart_q) begin
            if (scl_rise) phase_d = 1'b1;
          end else if (hold_done) begin
            scl_en_d = 1'b1;
            phase_d  = 1'b1;
          end
        end else begin
          if (rstart_q && hold_done) sda_d = 1'b0;
          if (scl_fall) begin done_d = 1'b1; scl_wait_d = 1'b1; end
        end
      end
      S_WRITE: begin
        scl_wait_d = 1'b0;
        if (arb_hit) begin
          arb_d    = 1'b1;
          done_d   = 1'b1;
          sda_d    = 1'b1;
          scl_en_d = 1'b0;
        end else begin
          if (hold_done) sda_d = shift_q[3'd7 - bit_q[2:0]];
          if (scl_fall)  bit_d = bit_q + 4'd1;
        end
      end
      S_ACK: begin
        if (hold_done) sda_d = 1'b1;
        if (scl_rise)  rx_ack_d = sda_i;
        if (scl_fall)  begin done_d = 1'b1; scl_wait_d = 1'b1; end
      end
      S_READ: begin
        scl_wait_d = 1'b0;
        if (hold_done) sda_d = (bit_q == 4'd8) ? tx_ack_q : 1'b1;
        if (scl_rise && bit_q != 4'd8) shift_d = {shift_q[6:0], sda_i};
        if (scl_fall) begin
          if (bit_q == 4'd8) begin
            rx_data_d  = shift_q;
            done_d     = 1'b1;
            scl_wait_d = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (!phase_q) begin
          if (hold_done) begin sda_d = 1'b0; scl_wait_d = 1'b0; end
          if (scl_rise)  phase_d = 1'b1;
        end else if (hold_done) begin
          sda_d    = 1'b1;
          scl_en_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The hold timer restarts on every state, phase or bit boundary and then saturates.
  assign hold_restart = (state_d != state_q) || (phase_d != phase_q) ||
                        (scl_fall && (state_q == S_WRITE || state_q == S_READ));
  assign hold_d = hold_restart ? '0 : (hold_done ? hold_q : hold_q + CNT_W'(1));

  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign rx_ack   = rx_ack_q;
  assign busy     = (state_q != S_IDLE);
  assign arb_lost = arb_q;
  assign scl_en   = scl_en_q;
  assign scl_wait = scl_wait_q;
  assign sda_o    = sda_q;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Bench for i2c_bit_engine: SCL generator and slave model drive the bus; a scoreboard
// monitor compares every done pulse (bits seen on SCL rises, rx_data, rx_ack, arb_lost).
module tb_i2c_bit_engine;

  localparam int HALF = 8;
  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_WRITE = 2'd1;
  localparam logic [1:0] C_READ  = 2'd2;
  localparam logic [1:0] C_STOP  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ack = 1'b1;
  logic       cmd_ready, done, rx_ack, busy, arb_lost, scl_en, scl_wait, sda_o;
  logic [7:0] rx_data;
  logic       scl_line = 1'b1;
  logic       slave_sda = 1'b1;
  logic       force_low = 1'b0;
  logic       sda_line;
  int         gcnt = 0;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int txn_id = 0;

  typedef struct {
    int         id;
    logic [7:0] rx_data;
    logic       chk_data;
    logic       rx_ack;
    logic       chk_ack;
    logic       arb;
    int         nbits;
    logic [8:0] bits;
  } exp_t;
  exp_t sbq[$];

  assign sda_line = sda_o & slave_sda & ~force_low;

  i2c_bit_engine #(.HOLD_CYC(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .tx_data(tx_data), .tx_ack(tx_ack), .done(done), .rx_data(rx_data), .rx_ack(rx_ack),
    .busy(busy), .arb_lost(arb_lost), .scl_en(scl_en), .scl_wait(scl_wait),
    .scl_i(scl_line), .sda_i(sda_line), .sda_o(sda_o)
  );

  always #5 clk = ~clk;

  // SCL generator: released high when disabled, held low while waiting, else free-running.
  always @(posedge clk) begin
    if (rst || !scl_en) begin
      scl_line <= 1'b1;
      gcnt     <= 0;
    end else if (scl_wait) begin
      scl_line <= 1'b0;
      gcnt     <= 0;
    end else if (gcnt == HALF - 1) begin
      scl_line <= ~scl_line;
      gcnt     <= 0;
    end else begin
      gcnt <= gcnt + 1;
    end
  end

  task automatic report(input string name, input logic ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    report(name, act === exp, int'(act), int'(exp));
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    report(name, act === exp, int'(act), int'(exp));
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    report(name, act == exp, act, exp);
  endtask

  task automatic expect_txn(input logic [7:0] rd, input logic cd, input logic ra, input logic ca,
                            input logic ar, input int nb, input logic [8:0] bits);
    exp_t e;
    txn_id++;
    e.id = txn_id; e.rx_data = rd; e.chk_data = cd; e.rx_ack = ra; e.chk_ack = ca;
    e.arb = ar; e.nbits = nb; e.bits = bits;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic a);
    int t;
    t = 0;
    @(negedge clk);
    cmd = c; tx_data = d; tx_ack = a; cmd_valid = 1'b1;
    while (!cmd_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check_bit("cmd_ready_timeout", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    $display("issued cmd=%0d data=%02h ack=%0b at %0t", c, d, a, $time);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 4000);
    if (!done) check_bit("done_timeout", done, 1'b1);
  endtask

  task automatic wait_falls(input int n);
    int cnt, t;
    logic prev;
    cnt = 0; t = 0; prev = scl_line;
    while (cnt < n && t < 4000) begin
      @(negedge clk);
      t++;
      if (prev && !scl_line) cnt++;
      prev = scl_line;
    end
    if (cnt < n) check_int("scl_fall_timeout", cnt, n);
  endtask

  task automatic do_write(input logic [7:0] d);
    int n;
    issue(C_WRITE, d, 1'b1);
    wait_falls(8);
    slave_sda = 1'b0;
    wait_falls(1);
    slave_sda = 1'b1;
    wait_done(n);
  endtask

  task automatic do_read(input logic [7:0] d, input logic a);
    int n;
    slave_sda = d[7];
    issue(C_READ, 8'h00, a);
    for (int i = 6; i >= 0; i--) begin
      wait_falls(1);
      slave_sda = d[i];
    end
    wait_falls(1);
    slave_sda = 1'b1;
    wait_done(n);
  endtask

  task automatic simple(input logic [1:0] c, input int nb, input logic [8:0] bits);
    int n;
    expect_txn(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, nb, bits);
    issue(c, 8'h00, 1'b1);
    wait_done(n);
  endtask

  // Scoreboard monitor: records SDA at each SCL rise and bus conditions, checks on done.
  initial begin : monitor
    logic sp, dp;
    int rn;
    logic [8:0] rb;
    exp_t e;
    sp = 1'b1; dp = 1'b1; rn = 0; rb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sp = 1'b1; dp = 1'b1; rn = 0; rb = '0;
      end else begin
        if (!sp && scl_line) begin
          rb = {rb[7:0], sda_line};
          rn++;
        end
        if (sp && scl_line && dp && !sda_line) start_cnt++;
        if (sp && scl_line && !dp && sda_line) stop_cnt++;
        sp = scl_line;
        dp = sda_line;
        if (done) begin
          if (sbq.size() == 0) begin
            check_bit("unexpected_done", done, 1'b0);
          end else begin
            e = sbq.pop_front();
            check_bit($sformatf("txn%0d arb_lost", e.id), arb_lost, e.arb);
            check_int($sformatf("txn%0d nbits", e.id), rn, e.nbits);
            check_int($sformatf("txn%0d sda_bits", e.id), int'(rb), int'(e.bits));
            if (e.chk_ack)  check_bit($sformatf("txn%0d rx_ack", e.id), rx_ack, e.rx_ack);
            if (e.chk_data) check_byte($sformatf("txn%0d rx_data", e.id), rx_data, e.rx_data);
            $display("done txn%0d rx_data=%02h rx_ack=%0b arb=%0b bits=%0d:%03h",
                     e.id, rx_data, rx_ack, arb_lost, rn, rb);
          end
          rn = 0;
          rb = '0;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, s0, p0, dcount;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_bit("rst cmd_ready", cmd_ready, 1'b1);
    check_bit("rst busy", busy, 1'b0);
    check_bit("rst sda_o", sda_o, 1'b1);
    check_bit("rst scl_en", scl_en, 1'b0);
    check_bit("rst scl_wait", scl_wait, 1'b0);
    check_bit("rst done", done, 1'b0);
    check_bit("rst arb_lost", arb_lost, 1'b0);
    check_byte("rst rx_data", rx_data, 8'h00);
    check_bit("rst rx_ack", rx_ack, 1'b1);

    // START, WRITE A5 acked, STOP
    s0 = start_cnt; p0 = stop_cnt;
    simple(C_START, 0, 9'h000);
    @(negedge clk);
    check_int("start_condition", start_cnt, s0 + 1);
    expect_txn(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9, 9'b101001010);
    do_write(8'hA5);
    simple(C_STOP, 1, 9'b0);
    @(negedge clk);
    check_int("stop_condition", stop_cnt, p0 + 1);
    check_bit("end busy", busy, 1'b0);
    check_bit("end sda_o", sda_o, 1'b1);
    check_bit("end scl_en", scl_en, 1'b0);

    // STOP and READ while idle: immediate done, no bus activity
    simple(C_STOP, 0, 9'h000);
    expect_txn(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 0, 9'h000);
    issue(C_READ, 8'h00, 1'b0);
    wait_done(n);
    check_int("idle_read_latency", n, 1);
    check_bit("idle scl_en", scl_en, 1'b0);
    check_bit("idle sda_o", sda_o, 1'b1);
    check_bit("idle busy", busy, 1'b0);

    // READ 3C with NACK, READ C3 with ACK
    simple(C_START, 0, 9'h000);
    expect_txn(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 9, 9'b001111001);
    do_read(8'h3C, 1'b1);
    expect_txn(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 9, 9'b110000110);
    do_read(8'hC3, 1'b0);
    simple(C_STOP, 1, 9'b0);

    // Repeated start after a write, no STOP in between
    simple(C_START, 0, 9'h000);
    expect_txn(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9, 9'b010110100);
    do_write(8'h5A);
    s0 = start_cnt; p0 = stop_cnt;
    simple(C_START, 1, 9'b1);
    @(negedge clk);
    check_int("rstart start_condition", start_cnt, s0 + 1);
    check_int("rstart no_stop", stop_cnt, p0);
    check_bit("rstart busy", busy, 1'b1);
    simple(C_STOP, 1, 9'b0);

    // Arbitration loss: SDA pulled low during bit 6 of WRITE FF
    simple(C_START, 0, 9'h000);
    expect_txn(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2, 9'b10);
    issue(C_WRITE, 8'hFF, 1'b1);
    wait_falls(1);
    force_low = 1'b1;
    wait_done(n);
    @(negedge clk);
    check_bit("arb busy", busy, 1'b0);
    check_bit("arb scl_en", scl_en, 1'b0);
    check_bit("arb scl_wait", scl_wait, 1'b0);
    check_bit("arb sda_o", sda_o, 1'b1);
    force_low = 1'b0;

    // Reset during the 5th bit of a WRITE: abort silently
    simple(C_START, 0, 9'h000);
    issue(C_WRITE, 8'h96, 1'b1);
    wait_falls(4);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_bit("abort sda_o", sda_o, 1'b1);
    check_bit("abort scl_en", scl_en, 1'b0);
    check_bit("abort scl_wait", scl_wait, 1'b0);
    check_bit("abort busy", busy, 1'b0);
    check_bit("abort done", done, 1'b0);
    check_bit("abort cmd_ready", cmd_ready, 1'b1);
    check_byte("abort rx_data", rx_data, 8'h00);
    check_bit("abort rx_ack", rx_ack, 1'b1);
    rst = 1'b0;
    dcount = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check_int("abort no_done", dcount, 0);

    check_int("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
